// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: result computed at Start, committed after MULT_CYCLES/DIV_CYCLES.
// Busy is high for exactly N cycles; Start while Busy is dropped (caller must stall, no queueing).
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Start,
    input  logic [2:0]  Op,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic            commit_q, commit_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic            busy_q, busy_d;

    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, s_den, u_den;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign a_neg  = A[31];
    assign b_neg  = B[31];
    assign b_zero = (B == 32'd0);
    assign a_mag  = a_neg ? (32'd0 - A) : A;
    assign b_mag  = b_neg ? (32'd0 - B) : B;
    assign s_den  = b_zero ? 32'd1 : b_mag;
    assign u_den  = b_zero ? 32'd1 : B;
    assign q_mag  = a_mag / s_den;
    assign r_mag  = a_mag % s_den;
    assign q_s    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign r_s    = a_neg ? (32'd0 - r_mag) : r_mag;
    assign q_u    = A / u_den;
    assign r_u    = A % u_den;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        commit_d  = commit_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        if (state_q == IDLE) begin
            if (Start) begin
                case (Op)
                    OP_MULT, OP_MULTU: begin
                        {pend_hi_d, pend_lo_d} = (Op == OP_MULT) ? prod_s : prod_u;
                        commit_d = 1'b1;
                        cnt_d    = CW'(MULT_CYCLES);
                        state_d  = RUN;
                        busy_d   = 1'b1;
                    end
                    OP_DIV, OP_DIVU: begin
                        pend_lo_d = (Op == OP_DIV) ? q_s : q_u;
                        pend_hi_d = (Op == OP_DIV) ? r_s : r_u;
                        // Divide by zero still occupies the unit but leaves HI/LO untouched.
                        commit_d  = !b_zero;
                        cnt_d     = CW'(DIV_CYCLES);
                        state_d   = RUN;
                        busy_d    = 1'b1;
                    end
                    OP_MTHI: hi_d = A;
                    OP_MTLO: lo_d = A;
                    default: ;
                endcase
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                if (commit_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            commit_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            commit_q  <= commit_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule
